// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline, covering load-use,
// cache-miss freezes, mispredict recovery, the mul/div handshake and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_imem_read,
   input  logic             i_imem_resp,
   input  logic             i_dmem_req,
   input  logic             i_dmem_resp,
   input  logic [4:0]       i_ifid_rs1,
   input  logic [4:0]       i_ifid_rs2,
   input  logic             i_ifid_uses_rs1,
   input  logic             i_ifid_uses_rs2,
   input  logic             i_idex_mem_read,
   input  logic [4:0]       i_idex_rd,
   input  logic             i_ex_mispredict,
   input  logic             i_ex_md_valid,
   input  logic             i_md_done,
   output logic             o_md_go,
   output logic             o_pc_en,
   output logic             o_pc_redirect,
   output logic             o_ifid_en,
   output logic             o_ifid_flush,
   output logic             o_idex_en,
   output logic             o_idex_flush,
   output logic             o_exmem_en,
   output logic             o_exmem_flush,
   output logic             o_memwb_en,
   output logic             o_memwb_flush,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count
);
   typedef enum logic [1:0] {RUN, MD_BUSY, DRAIN} state_t;
   state_t r_state, w_next;
   logic r_md_pend;
   logic w_mem_stall, w_if_stall, w_load_use, w_md_done;
   logic w_md_go, w_pc_en, w_redir, w_ifid_en, w_ifid_fl, w_idex_en, w_idex_fl;
   logic w_exmem_en, w_memwb_en;
   assign w_mem_stall = i_dmem_req & ~i_dmem_resp;
   assign w_if_stall  = i_imem_read & ~i_imem_resp;
   assign w_load_use  = i_idex_mem_read & (i_idex_rd != 5'd0) &
                        ((i_ifid_uses_rs1 & (i_ifid_rs1 == i_idex_rd)) |
                         (i_ifid_uses_rs2 & (i_ifid_rs2 == i_idex_rd)));
   // a done pulse swallowed by a D-miss freeze is remembered until the freeze lifts
   assign w_md_done = i_md_done | r_md_pend;
   always_comb begin
      w_next     = r_state;
      w_md_go    = 1'b0;
      w_pc_en    = 1'b0;
      w_redir    = 1'b0;
      w_ifid_en  = 1'b0;
      w_ifid_fl  = 1'b0;
      w_idex_en  = 1'b0;
      w_idex_fl  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
      if (!w_mem_stall) begin
         case (r_state)
            RUN: begin
               if (i_ex_md_valid) begin
                  w_md_go = 1'b1;
                  w_next  = MD_BUSY;
               end else if (i_ex_mispredict) begin
                  w_pc_en    = 1'b1;
                  w_redir    = 1'b1;
                  w_ifid_en  = 1'b1;
                  w_ifid_fl  = 1'b1;
                  w_idex_en  = 1'b1;
                  w_idex_fl  = 1'b1;
                  w_exmem_en = 1'b1;
                  w_memwb_en = 1'b1;
                  w_next     = w_if_stall ? DRAIN : RUN;
               end else if (!w_if_stall) begin
                  w_pc_en    = ~w_load_use;
                  w_ifid_en  = ~w_load_use;
                  w_idex_en  = 1'b1;
                  w_idex_fl  = w_load_use;
                  w_exmem_en = 1'b1;
                  w_memwb_en = 1'b1;
               end
            end
            MD_BUSY: begin
               if (w_md_done) begin
                  w_pc_en    = 1'b1;
                  w_ifid_en  = 1'b1;
                  w_idex_en  = 1'b1;
                  w_exmem_en = 1'b1;
                  w_memwb_en = 1'b1;
                  w_next     = RUN;
               end
            end
            DRAIN: begin
               w_idex_en  = 1'b1;
               w_idex_fl  = 1'b1;
               w_exmem_en = 1'b1;
               w_memwb_en = 1'b1;
               w_ifid_en  = i_imem_resp;
               w_ifid_fl  = i_imem_resp;
               w_next     = i_imem_resp ? RUN : DRAIN;
            end
            default: w_next = RUN;
         endcase
      end
   end
   assign o_md_go       = w_md_go & ~rst;
   assign o_pc_en       = w_pc_en & ~rst;
   assign o_pc_redirect = w_redir & ~rst;
   assign o_ifid_en     = w_ifid_en & ~rst;
   assign o_ifid_flush  = w_ifid_fl & ~rst;
   assign o_idex_en     = w_idex_en & ~rst;
   assign o_idex_flush  = w_idex_fl & ~rst;
   assign o_exmem_en    = w_exmem_en & ~rst;
   assign o_exmem_flush = 1'b0;
   assign o_memwb_en    = w_memwb_en & ~rst;
   assign o_memwb_flush = 1'b0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= RUN;
         r_md_pend      <= 1'b0;
         o_stall_cycles <= '0;
         o_flush_count  <= '0;
      end else begin
         r_state   <= w_next;
         r_md_pend <= (r_state == MD_BUSY) & w_mem_stall & w_md_done;
         if (!w_memwb_en && o_stall_cycles != '1)
            o_stall_cycles <= o_stall_cycles + 1'b1;
         if (w_redir && o_flush_count != '1)
            o_flush_count <= o_flush_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector bench for pipeline_hazard_ctrl with
// hand-computed control vectors and counter values.
module tb_pipeline_hazard_ctrl;
   localparam int CNT_W = 32;
   // {md_go, pc_en, redirect, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
   localparam logic [10:0] ZERO = 11'b00000000000;
   localparam logic [10:0] NORM = 11'b01010101010;
   localparam logic [10:0] LU   = 11'b00000111010;
   localparam logic [10:0] MISP = 11'b01111111010;
   localparam logic [10:0] DRN  = 11'b00000111010;
   localparam logic [10:0] DRNR = 11'b00011111010;
   localparam logic [10:0] MDGO = 11'b10000000000;
   logic clk = 1'b0, rst;
   logic imem_read, imem_resp, dmem_req, dmem_resp;
   logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
   logic ifid_uses_rs1, ifid_uses_rs2, idex_mem_read, ex_mispredict, ex_md_valid, md_done;
   logic md_go, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush;
   logic exmem_en, exmem_flush, memwb_en, memwb_flush;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   int nvec = 0, nfail = 0;
   int exp_s = 0, exp_f = 0;
   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .i_imem_read(imem_read), .i_imem_resp(imem_resp),
      .i_dmem_req(dmem_req), .i_dmem_resp(dmem_resp),
      .i_ifid_rs1(ifid_rs1), .i_ifid_rs2(ifid_rs2),
      .i_ifid_uses_rs1(ifid_uses_rs1), .i_ifid_uses_rs2(ifid_uses_rs2),
      .i_idex_mem_read(idex_mem_read), .i_idex_rd(idex_rd),
      .i_ex_mispredict(ex_mispredict), .i_ex_md_valid(ex_md_valid), .i_md_done(md_done),
      .o_md_go(md_go), .o_pc_en(pc_en), .o_pc_redirect(pc_redirect),
      .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
      .o_idex_en(idex_en), .o_idex_flush(idex_flush),
      .o_exmem_en(exmem_en), .o_exmem_flush(exmem_flush),
      .o_memwb_en(memwb_en), .o_memwb_flush(memwb_flush),
      .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
   );
   always #5 clk = ~clk;
   task automatic clr();
      imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
      ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0;
      idex_mem_read = 0; idex_rd = 0; ex_mispredict = 0; ex_md_valid = 0; md_done = 0;
   endtask
   task automatic chk(input string tag, input logic [10:0] exp);
      logic [10:0] obs;
      #2;
      obs = {md_go, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, memwb_flush};
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: ctl got %b expected %b", tag, obs, exp);
      end
   endtask
   task automatic chkc(input string tag);
      nvec++;
      assert (stall_cycles === CNT_W'(exp_s) && flush_count === CNT_W'(exp_f)) else begin
         nfail++;
         $error("FAIL %s: stall/flush got %0d/%0d expected %0d/%0d",
                tag, stall_cycles, flush_count, exp_s, exp_f);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1; clr();
      ex_mispredict = 1;
      chk("reset_gated", ZERO);
      chkc("reset_cnt");
      #4;
      rst = 0; ex_mispredict = 0;
      chk("normal", NORM); tick();
      chkc("normal_cnt");
      idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_uses_rs1 = 1; ifid_rs2 = 1; ifid_uses_rs2 = 1;
      chk("load_use_rs1", LU); tick();
      idex_mem_read = 0;
      chk("after_lu", NORM); tick();
      chkc("lu_cnt");
      idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 3; ifid_rs2 = 7;
      chk("load_use_rs2", LU); tick();
      ifid_uses_rs2 = 0;
      chk("rs2_unused", NORM); tick();
      idex_rd = 0; ifid_rs1 = 0;
      chk("rd_x0", NORM); tick();
      clr(); ex_mispredict = 1; idex_mem_read = 1; idex_rd = 2; ifid_rs1 = 2; ifid_uses_rs1 = 1;
      chk("misp_over_lu", MISP); tick(); exp_f = 1;
      clr();
      chkc("misp_cnt");
      chk("after_misp", NORM); tick();
      imem_read = 1; ex_mispredict = 1;
      chk("misp_imiss", MISP); tick(); exp_f = 2;
      ex_mispredict = 0;
      chk("drain1", DRN); tick();
      chk("drain2", DRN); tick();
      imem_resp = 1;
      chk("drain_resp", DRNR); tick();
      clr();
      chk("drain_exit", NORM); tick();
      chkc("drain_cnt");
      imem_read = 1;
      chk("imiss_freeze", ZERO); tick(); exp_s = 1;
      clr(); dmem_req = 1; ex_mispredict = 1;
      for (int i = 0; i < 4; i++) begin
         chk("dmiss_freeze", ZERO); tick(); exp_s++;
      end
      chkc("dmiss_cnt");
      dmem_resp = 1;
      chk("dmiss_resp_misp", MISP); tick(); exp_f = 3;
      clr();
      chkc("dmiss_misp_cnt");
      ex_md_valid = 1;
      chk("md_go", MDGO); tick(); exp_s++;
      for (int i = 0; i < 4; i++) begin
         chk("md_busy", ZERO); tick(); exp_s++;
      end
      md_done = 1;
      chk("md_done", NORM); tick();
      md_done = 0; ex_md_valid = 0;
      chk("md_back_run", NORM); tick();
      chkc("md_cnt");
      ex_md_valid = 1;
      chk("md_go2", MDGO); tick(); exp_s++;
      md_done = 1; dmem_req = 1;
      chk("md_done_dmiss", ZERO); tick(); exp_s++;
      md_done = 0; dmem_resp = 1;
      chk("md_done_held", NORM); tick();
      clr();
      chk("md2_back_run", NORM); tick();
      chkc("md2_cnt");
      imem_read = 1; ex_mispredict = 1;
      chk("misp_imiss2", MISP); tick(); exp_f++;
      ex_mispredict = 0;
      chk("drain_pre_rst", DRN);
      rst = 1; exp_s = 0; exp_f = 0;
      chk("rst_async_ctl", ZERO);
      chkc("rst_async_cnt");
      #2;
      rst = 0;
      chk("post_rst_run", ZERO); tick(); exp_s = 1;
      chkc("post_rst_cnt");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
